mult_issue_ctrl: RTL and testbench
==================================

Name: mult_issue_ctrl

Overview:
Sequential issue/retire controller for the combinational 32x32 unsigned array multiplier stage.
- Upstream: accepts one operand pair per transaction over a valid/ready handshake.
- Optional signed mode: converts signed operands to magnitudes before they reach the multiplier.
- Holds the multiplier inputs stable for a fixed number of settle cycles, then captures the 2*WIDTH product.
- Downstream: applies the sign correction and presents the result on a valid/ready handshake.

Parameters:
- WIDTH, 32, operand width. Product is 2*WIDTH bits.
- SETTLE_CYCLES, 4, clock edges the multiplier inputs are held before the product is sampled. Legal range is 1..255. A value of 0 is treated as 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  controller can accept an operand pair
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled on accept
- mul_a  output  WIDTH  registered magnitude of A, driven to the multiplier
- mul_b  output  WIDTH  registered magnitude of B, driven to the multiplier
- mul_pro  input  2*WIDTH  unsigned product returned by the multiplier
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_pro  output  2*WIDTH  final product
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high):
  - state <= IDLE; count <= 0; neg flag <= 0.
  - mul_a, mul_b, out_pro <= 0.
  - out_valid <= 0; busy = 0; in_ready = 1 once rst deasserts.
- States: IDLE, SETTLE, DONE.
  - in_ready = (state == IDLE).
  - busy = (state != IDLE).
- IDLE:
  - Accept occurs on an edge where in_valid & in_ready.
  - mul_a <= (in_signed & in_a[WIDTH-1]) ? -in_a : in_a. mul_b is formed the same way from in_b.
  - neg <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]).
  - count <= SETTLE_CYCLES-1; state <= SETTLE.
- SETTLE:
  - mul_a and mul_b must not change.
  - At each edge: if count != 0, count <= count-1.
  - Otherwise capture: out_pro <= neg ? (~mul_pro + 1) : mul_pro (2*WIDTH two's complement); out_valid <= 1; state <= DONE.
- DONE:
  - out_pro and out_valid hold until out_valid & out_ready.
  - On that edge: out_valid <= 0; state <= IDLE.
  - mul_a and mul_b keep their last values.
- Latency:
  - Accept at edge t0 gives the capture edge t0+SETTLE_CYCLES.
  - out_valid is visible in the cycle after the capture edge.
  - Minimum spacing between accepts is SETTLE_CYCLES+2 edges when out_ready is held high.
- Non-pipelined: one transaction in flight. in_valid asserted while busy is ignored and is not latched; the upstream stage must hold it.
- Magnitude edge case: the most negative input (-2^(WIDTH-1)) negates to itself. Read as unsigned, that is the correct magnitude, so no special case is needed.
- Products of magnitudes fit in 2*WIDTH bits, so there is no overflow. A signed zero product with neg=1 yields 0.
- in_signed=0: neg is always 0 and operands pass through unchanged.
- Reset mid-operation (SETTLE or DONE): the transaction is dropped, nothing is emitted, and state returns to IDLE.
- out_ready asserted while out_valid=0 has no effect.

Test Plan:
1. Unsigned transfer, SETTLE_CYCLES=4: in_a=3, in_b=5, in_signed=0, out_ready=1.
   - mul_a=3, mul_b=5 after the accept edge.
   - out_valid rises after edge t0+4 with out_pro=0x0000_0000_0000_000F.
   - in_ready returns high one edge later.
2. Signed negative product: in_a=0xFFFF_FFFD (-3), in_b=5, in_signed=1.
   - mul_a=3.
   - out_pro=0xFFFF_FFFF_FFFF_FFF1.
3. Boundary values:
   - Signed in_a=in_b=0x8000_0000 gives mul_a=0x8000_0000 and out_pro=0x4000_0000_0000_0000.
   - Unsigned in_a=in_b=0xFFFF_FFFF gives out_pro=0xFFFF_FFFE_0000_0001.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid.
   - out_pro and out_valid are stable throughout; in_ready=0 throughout.
   - A new in_valid pulse during DONE is ignored.
   - Raising out_ready completes the transfer and returns to IDLE.
5. Reset mid-SETTLE: assert rst two edges after accept.
   - All outputs go to 0 immediately (asynchronous).
   - No out_valid is produced.
   - The next transaction, 7*6, gives 42.
6. SETTLE_CYCLES=1 build: the product is captured on the first edge after accept.
   - Back-to-back transactions with out_ready=1 are accepted every 3 edges, each with the correct product.

Source files
------------

// File: rtl/mult_issue_ctrl.sv
// Issue/retire controller for a combinational WIDTH x WIDTH unsigned multiplier:
// takes signed or unsigned operands, feeds magnitudes, waits for settle, returns the corrected product.
module mult_issue_ctrl #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  input  logic [2*WIDTH-1:0]   mul_pro,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_pro,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
  // The producer holds valid and its data stable until that edge; valid never waits on ready.

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  // A settle count of 0 would sample before the inputs are even applied, so it behaves as 1.
  localparam int         SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [7:0] COUNT_INIT = 8'(SETTLE_EFF - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [7:0]       count;
  logic             neg;
  logic             accept;
  logic             capture;
  logic             release_out;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  assign accept      = in_valid & in_ready;
  assign capture     = (state == SETTLE) && (count == 8'd0);
  assign release_out = (state == DONE) && out_valid && out_ready;

  // The most negative value negates to itself, which read unsigned is already its magnitude.
  assign mag_a = (in_signed & in_a[WIDTH-1]) ? -in_a : in_a;
  assign mag_b = (in_signed & in_b[WIDTH-1]) ? -in_b : in_b;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = SETTLE;
      SETTLE:  if (capture)     state_nxt = DONE;
      DONE:    if (release_out) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Multiplier inputs only move on accept, so they stay frozen through SETTLE and DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a <= '0;
      mul_b <= '0;
      neg   <= 1'b0;
    end else if (accept) begin
      mul_a <= mag_a;
      mul_b <= mag_b;
      neg   <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (accept) begin
      count <= COUNT_INIT;
    end else if ((state == SETTLE) && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  // Sign correction is a 2*WIDTH negate; a zero product stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pro   <= '0;
      out_valid <= 1'b0;
    end else if (capture) begin
      out_pro   <= neg ? -mul_pro : mul_pro;
      out_valid <= 1'b1;
    end else if (release_out) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Randomized plus directed bench for mult_issue_ctrl: a settle-aware multiplier model,
// a scoreboard of expected products and arrival cycles, and a SETTLE_CYCLES=1 instance.
module tb_mult_issue_ctrl;

  localparam int W  = 32;
  localparam int S  = 4;
  localparam int S1 = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (SETTLE_CYCLES = 4) ----------------
  logic          in_valid = 1'b0, in_signed = 1'b0, out_ready = 1'b1;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic          in_ready, out_valid, busy;
  logic [W-1:0]  mul_a, mul_b;
  logic [2*W-1:0] mul_pro, out_pro;
  logic [1:0]    dbg_state;

  mult_issue_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .mul_a(mul_a), .mul_b(mul_b), .mul_pro(mul_pro),
    .out_valid(out_valid), .out_ready(out_ready), .out_pro(out_pro),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- second DUT (SETTLE_CYCLES = 1) ----------------
  logic          in_valid1 = 1'b0, in_signed1 = 1'b0, out_ready1 = 1'b1;
  logic [W-1:0]  in_a1 = '0, in_b1 = '0;
  logic          in_ready1, out_valid1, busy1;
  logic [W-1:0]  mul_a1, mul_b1;
  logic [2*W-1:0] mul_pro1, out_pro1;
  logic [1:0]    dbg_state1;

  mult_issue_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_signed(in_signed1),
    .mul_a(mul_a1), .mul_b(mul_b1), .mul_pro(mul_pro1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_pro(out_pro1),
    .busy(busy1), .dbg_state(dbg_state1)
  );

  // ---------------- multiplier models: garbage until inputs stable long enough ----------------
  int stab = 0, stab1 = 0;
  logic [W-1:0] pa = '0, pb = '0, pa1 = '0, pb1 = '0;
  logic [2*W-1:0] true_pro, true_pro1;

  assign true_pro  = {32'd0, mul_a} * {32'd0, mul_b};
  assign true_pro1 = {32'd0, mul_a1} * {32'd0, mul_b1};
  assign mul_pro   = (stab  >= S)  ? true_pro  : ~true_pro;
  assign mul_pro1  = (stab1 >= S1) ? true_pro1 : ~true_pro1;

  always @(negedge clk) begin
    if (mul_a !== pa || mul_b !== pb) stab = 1;
    else if (stab < 1000) stab++;
    pa = mul_a; pb = mul_b;
    if (mul_a1 !== pa1 || mul_b1 !== pb1) stab1 = 1;
    else if (stab1 < 1000) stab1++;
    pa1 = mul_a1; pb1 = mul_b1;
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    sa = s ? {{32{a[31]}}, a} : {32'd0, a};
    sb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return sa * sb;
  endfunction

  function automatic logic [31:0] ref_mag(input logic [31:0] a, input logic s);
    logic signed [63:0] v;
    v = s ? {{32{a[31]}}, a} : {32'd0, a};
    if (v < 0) v = -v;
    return v[31:0];
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 4))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  int tests = 0, failed = 0;
  logic [63:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [63:0] cur_exp = '0;
  bit          seen = 1'b0;
  logic [63:0] exp1_q[$];
  int          acc1_q[$];
  int          last_acc1 = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Main monitor: first cycle of out_valid pops an expectation, later cycles check hold.
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(out_valid), 64'(0));
        end else begin
          cur_exp = exp_q.pop_front();
          check("product", out_pro, cur_exp);
          check("latency", 64'(cyc), 64'(exp_cyc_q.pop_front() + S));
        end
      end else if (out_valid && seen) begin
        check("hold_pro", out_pro, cur_exp);
        check("hold_in_ready", 64'(in_ready), 64'(0));
      end
      if (out_valid && out_ready) seen = 1'b0;
    end
  end

  // SETTLE_CYCLES=1 monitor: records accepts, checks spacing, latency and product.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid1 && in_ready1) begin
        exp1_q.push_back(ref_mul(in_a1, in_b1, in_signed1));
        if (last_acc1 >= 0) check("b2b_spacing", 64'(cyc - last_acc1), 64'(3));
        last_acc1 = cyc;
        acc1_q.push_back(cyc);
      end
      if (out_valid1 && out_ready1) begin
        if (exp1_q.size() == 0) begin
          check("s1_unexpected_out", 64'(out_valid1), 64'(0));
        end else begin
          check("s1_product", out_pro1, exp1_q.pop_front());
          check("s1_latency", 64'(cyc), 64'(acc1_q.pop_front() + 2));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  bit rand_ready = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Call at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
    int n = 0;
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(ref_mul(a, b, s));
    exp_cyc_q.push_back(cyc);
    check("mul_a", 64'(mul_a), 64'(ref_mag(a, s)));
    check("mul_b", 64'(mul_b), 64'(ref_mag(b, s)));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin @(negedge clk); n++; end
    check("drain", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int acc, n;
    logic [63:0] hold_exp;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_mul_a", 64'(mul_a), 64'(0));
    check("rst_out_pro", out_pro, 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // 1: unsigned 3*5, then in_ready one edge after out_valid
    out_ready = 1'b1;
    send(32'd3, 32'd5, 1'b0);
    acc = cyc; n = 0;
    while (cyc < acc + S && n < 50) begin @(negedge clk); n++; end
    check("t1_out_valid", 64'(out_valid), 64'(1));
    check("t1_out_pro", out_pro, 64'h0000_0000_0000_000F);
    @(negedge clk);
    check("t1_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // 2 and 3: signed negative and boundary values
    send(32'hFFFF_FFFD, 32'd5, 1'b1);
    drain();
    send(32'h8000_0000, 32'h8000_0000, 1'b1);
    drain();
    check("t3_signed_min", cur_exp, 64'h4000_0000_0000_0000);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    drain();
    check("t3_unsigned_max", out_pro, 64'hFFFF_FFFE_0000_0001);

    // 4: backpressure with an ignored in_valid pulse during DONE
    out_ready = 1'b0;
    a = 32'hFFFF_FF00; b = 32'd1000;
    hold_exp = ref_mul(a, b, 1'b1);
    send(a, b, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_out_pro", out_pro, hold_exp);
      check("bp_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
      in_valid = (i == 3);
      in_a = 32'd77; in_b = 32'd88; in_signed = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    check("bp_mul_a_kept", 64'(mul_a), 64'(ref_mag(a, 1'b1)));
    check("bp_idle", 64'(in_ready), 64'(1));

    // 5: reset mid-SETTLE drops the transaction
    send(32'd9, 32'd9, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_mul_a", 64'(mul_a), 64'(0));
    check("mid_rst_mul_b", 64'(mul_b), 64'(0));
    check("mid_rst_out_pro", out_pro, 64'(0));
    void'(exp_q.pop_back());
    void'(exp_cyc_q.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (S + 4) @(posedge clk);
    #1;
    send(32'd7, 32'd6, 1'b0);
    drain();
    check("post_rst_42", out_pro, 64'd42);

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    // 6: SETTLE_CYCLES=1 back-to-back accepts every 3 edges
    out_ready1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_a1 = rnd_op(); in_b1 = rnd_op(); in_signed1 = 1'($urandom_range(0, 1));
      in_valid1 = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready1 && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1;
    end
    in_valid1 = 1'b0;
    n = 0;
    while ((exp1_q.size() != 0 || out_valid1) && n < 100) begin @(negedge clk); n++; end
    check("s1_drain", 64'(exp1_q.size()), 64'(0));
    check("s1_count", 64'(last_acc1 >= 0), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
